// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters.
// Holds ce for exactly one transfer, reissues after master errors, and abandons hung transfers.
`timescale 1ns/1ps
module i2c_request_arbiter #(
    parameter int NREQ        = 4,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [8*NREQ-1:0]       req_addr,
    input  logic [8*NREQ-1:0]       req_wdata,
    output logic [NREQ-1:0]         req_ack,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [7:0]              rsp_rdata,
    output logic [1:0]              rsp_err,
    output logic                    m_ce,
    output logic                    m_wren,
    output logic                    m_rden,
    output logic [7:0]              m_addr,
    output logic [7:0]              m_wdata,
    input  logic [7:0]              m_rdata,
    input  logic                    m_ready,
    input  logic                    m_error,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int CW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_err_q, rsp_err_d;
    logic            m_ce_q, m_ce_d;
    logic            m_wren_q, m_wren_d;
    logic            m_rden_q, m_rden_d;
    logic [7:0]      m_addr_q, m_addr_d;
    logic [7:0]      m_wdata_q, m_wdata_d;
    logic            wr_q, wr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timeout_q, timeout_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic            reissue_q, reissue_d;

    logic [7:0]      addr_arr  [NREQ];
    logic [7:0]      wdata_arr [NREQ];
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   scan_idx;
    logic            xfer_end;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[8*gi +: 8];
            assign wdata_arr[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    // Scan starts one past the last grant and wraps, so the last winner has lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = last_grant_q;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (scan_idx == GW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ack_d    = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        m_ce_d       = m_ce_q;
        m_wren_d     = m_wren_q;
        m_rden_d     = m_rden_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        wr_d         = wr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        retry_d      = retry_q;
        timeout_d    = timeout_q;
        gap_d        = gap_q;
        reissue_d    = reissue_q;
        xfer_end     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    req_ack_d[pick_idx] = 1'b1;
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    wr_d         = req_wr[pick_idx];
                    m_addr_d     = addr_arr[pick_idx];
                    m_wdata_d    = wdata_arr[pick_idx];
                    m_ce_d       = 1'b1;
                    m_wren_d     = req_wr[pick_idx];
                    m_rden_d     = !req_wr[pick_idx];
                    timeout_d    = '0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                timeout_d = timeout_q + 1'b1;
                // Priority: error over ready, and either over the timeout.
                if (m_error) begin
                    xfer_end = 1'b1;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d   = retry_q + 1'b1;
                        reissue_d = 1'b1;
                    end else begin
                        rsp_valid_d[grant_q] = 1'b1;
                        rsp_err_d            = 2'b01;
                    end
                end else if (m_ready) begin
                    xfer_end             = 1'b1;
                    rsp_rdata_d          = m_rdata;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 2'b00;
                end else if (timeout_q == TW'(TIMEOUT_CYC - 1)) begin
                    xfer_end             = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 2'b10;
                end
                if (xfer_end) begin
                    m_ce_d   = 1'b0;
                    m_wren_d = 1'b0;
                    m_rden_d = 1'b0;
                    gap_d    = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == CW'(GAP_CYC - 1)) begin
                    if (reissue_q) begin
                        reissue_d = 1'b0;
                        m_ce_d    = 1'b1;
                        m_wren_d  = wr_q;
                        m_rden_d  = !wr_q;
                        timeout_d = '0;
                        state_d   = WAIT;
                    end else begin
                        retry_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_ack_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= '0;
            m_ce_q       <= 1'b0;
            m_wren_q     <= 1'b0;
            m_rden_q     <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            wr_q         <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            retry_q      <= '0;
            timeout_q    <= '0;
            gap_q        <= '0;
            reissue_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ack_q    <= req_ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            m_ce_q       <= m_ce_d;
            m_wren_q     <= m_wren_d;
            m_rden_q     <= m_rden_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            wr_q         <= wr_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            retry_q      <= retry_d;
            timeout_q    <= timeout_d;
            gap_q        <= gap_d;
            reissue_q    <= reissue_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_ce      = m_ce_q;
    assign m_wren    = m_wren_q;
    assign m_rden    = m_rden_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Directed bench for i2c_request_arbiter: vector table for single transfers with retries,
// plus hand sequences for reset, round-robin order, withdrawal and timeout races.
`timescale 1ns/1ps
module tb_i2c_request_arbiter;

    localparam int NREQ        = 4;
    localparam int MAX_RETRY   = 2;
    localparam int TIMEOUT_CYC = 4096;
    localparam int GAP_CYC     = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_wr = '0;
    logic [8*NREQ-1:0]   req_addr = '0;
    logic [8*NREQ-1:0]   req_wdata = '0;
    logic [NREQ-1:0]     req_ack;
    logic [NREQ-1:0]     rsp_valid;
    logic [7:0]          rsp_rdata;
    logic [1:0]          rsp_err;
    logic                m_ce, m_wren, m_rden;
    logic [7:0]          m_addr, m_wdata;
    logic [7:0]          m_rdata = '0;
    logic                m_ready = 1'b0;
    logic                m_error = 1'b0;
    logic                busy;
    logic [1:0]          grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2c_request_arbiter #(
        .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_ce(m_ce), .m_wren(m_wren), .m_rden(m_rden), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        int         rid;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         n_err;     // error pulses before the final ready
        logic       both;      // errors delivered together with m_ready
        logic [1:0] exp_err;
        int         exp_att;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int rid, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        req_wr[rid]             = wr;
        req_addr[8*rid +: 8]    = addr;
        req_wdata[8*rid +: 8]   = wd;
        req_valid[rid]          = 1'b1;
    endtask

    task automatic wait_ack(output int g);
        g = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                for (int i = NREQ - 1; i >= 0; i--)
                    if (req_ack[i]) g = i;
                break;
            end
        end
        n_tests++;
        if (g < 0) begin
            n_fail++;
            $display("FAIL ack_wait: no req_ack within 64 cycles, expected a grant");
        end else if (req_ack != (NREQ'(1) << g)) begin
            n_fail++;
            $display("FAIL ack_onehot: got 0x%0h, expected a single bit", req_ack);
        end
    endtask

    task automatic serve(input int exp_g, input logic [7:0] rd, input bit drop);
        int g;
        wait_ack(g);
        check("grant_order", g, exp_g);
        check("grant_id", grant_id, exp_g);
        if (drop) req_valid[exp_g] = 1'b0;
        repeat (2) @(negedge clk);
        m_ready = 1'b1;
        m_rdata = rd;
        @(negedge clk);
        m_ready = 1'b0;
        check("serve_rsp_valid", rsp_valid, 1 << exp_g);
        check("serve_rdata", rsp_rdata, rd);
        $display("[TB] serve grant=%0d rdata=0x%02h err=%0d", g, rsp_rdata, rsp_err);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 64 && busy; c++) @(negedge clk);
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cnt;
        vecs[0] = '{rid:1, wr:1'b0, addr:8'h41, wdata:8'h00, rdata:8'hA5, n_err:0, both:1'b0, exp_err:2'b00, exp_att:1};
        vecs[1] = '{rid:2, wr:1'b1, addr:8'h41, wdata:8'h5F, rdata:8'h00, n_err:2, both:1'b0, exp_err:2'b00, exp_att:3};
        vecs[2] = '{rid:3, wr:1'b1, addr:8'hC7, wdata:8'h3C, rdata:8'h00, n_err:3, both:1'b0, exp_err:2'b01, exp_att:3};
        vecs[3] = '{rid:0, wr:1'b0, addr:8'h82, wdata:8'h00, rdata:8'h5A, n_err:1, both:1'b1, exp_err:2'b00, exp_att:2};
        vecs[4] = '{rid:1, wr:1'b0, addr:8'h3F, wdata:8'h00, rdata:8'h81, n_err:3, both:1'b1, exp_err:2'b01, exp_att:3};

        repeat (3) @(negedge clk);
        check("rst_req_ack", req_ack, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_m_ce", m_ce, 0);
        check("rst_m_wren", m_wren, 0);
        check("rst_m_rden", m_rden, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            set_req(vecs[v].rid, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            wait_ack(g);
            check("vec_grant", g, vecs[v].rid);
            check("vec_grant_id", grant_id, vecs[v].rid);
            req_valid[vecs[v].rid] = 1'b0;
            for (int a = 0; a < vecs[v].exp_att; a++) begin
                check("vec_ce", m_ce, 1);
                check("vec_wren", m_wren, vecs[v].wr);
                check("vec_rden", m_rden, !vecs[v].wr);
                check("vec_addr", m_addr, vecs[v].addr);
                check("vec_wdata", m_wdata, vecs[v].wdata);
                repeat (2) @(negedge clk);
                if (a < vecs[v].n_err) begin
                    m_error = 1'b1;
                    m_ready = vecs[v].both;
                end else begin
                    m_ready = 1'b1;
                    m_rdata = vecs[v].rdata;
                end
                @(negedge clk);
                m_error = 1'b0;
                m_ready = 1'b0;
                m_rdata = 8'h00;
                check("vec_ce_drop", m_ce, 0);
                check("vec_wren_drop", m_wren, 0);
                check("vec_rden_drop", m_rden, 0);
                if (a == vecs[v].exp_att - 1) begin
                    check("vec_rsp_valid", rsp_valid, 1 << vecs[v].rid);
                    check("vec_rsp_err", rsp_err, vecs[v].exp_err);
                    if (vecs[v].exp_err == 2'b00) check("vec_rsp_rdata", rsp_rdata, vecs[v].rdata);
                end else begin
                    check("vec_no_rsp", rsp_valid, 0);
                end
                repeat (GAP_CYC - 1) @(negedge clk);
                check("vec_gap_ce_low", m_ce, 0);
                check("vec_gap_no_rsp", rsp_valid, 0);
                @(negedge clk);
                if (a == vecs[v].exp_att - 1) begin
                    check("vec_idle_busy", busy, 0);
                    check("vec_idle_ce", m_ce, 0);
                end else begin
                    check("vec_reissue_ce", m_ce, 1);
                end
            end
            $display("[TB] vec %0d rid=%0d wr=%0d addr=0x%02h attempts=%0d err=%0d rdata=0x%02h",
                     v, vecs[v].rid, vecs[v].wr, vecs[v].addr, vecs[v].exp_att, rsp_err, rsp_rdata);
        end

        // Reset during WAIT: ce drops asynchronously, no response, rotation restarts at 0.
        @(negedge clk);
        set_req(2, 1'b1, 8'h55, 8'h66);
        wait_ack(g);
        check("rstmid_grant", g, 2);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("rstmid_ce_before", m_ce, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_ce_async", m_ce, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_grant_id", grant_id, 0);
        repeat (2) @(negedge clk);
        check("rstmid_no_rsp", rsp_valid, 0);
        reset_n = 1'b1;
        $display("[TB] reset mid-transfer: m_ce=%0d busy=%0d", m_ce, busy);

        // Round-robin with all four requesting continuously.
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 8'(8'h10 + r), 8'h00);
        for (int k = 0; k < 5; k++) serve(k % NREQ, 8'(8'hB0 + k), 1'b0);
        req_valid = '0;

        // Last grant 0; 2 and 3 pending -> 2. Requester 1 arrives mid-transfer, 0 arrives and withdraws.
        req_valid = 4'b1100;
        wait_ack(g);
        check("late_first_grant", g, 2);
        req_valid[2] = 1'b0;
        req_valid[1] = 1'b1;
        req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        m_ready = 1'b1;
        m_rdata = 8'hC2;
        @(negedge clk);
        m_ready = 1'b0;
        check("late_rsp_valid", rsp_valid, 1 << 2);
        $display("[TB] serve grant=2 rdata=0x%02h err=%0d", rsp_rdata, rsp_err);
        repeat (5) @(negedge clk);
        req_valid[0] = 1'b0;
        serve(3, 8'hC3, 1'b1);
        serve(1, 8'hC1, 1'b1);
        wait_idle();
        repeat (4) @(negedge clk);
        check("withdrawn_no_ack", req_ack, 0);
        check("withdrawn_idle", busy, 0);

        // Timeout: master never answers.
        set_req(0, 1'b0, 8'h10, 8'h00);
        wait_ack(g);
        check("to_grant", g, 0);
        req_valid[0] = 1'b0;
        cnt = 1;
        while (m_ce && cnt < TIMEOUT_CYC + 10) begin
            @(negedge clk);
            if (m_ce) cnt++;
        end
        check("to_wait_cycles", cnt, TIMEOUT_CYC);
        check("to_rsp_valid", rsp_valid, 1 << 0);
        check("to_rsp_err", rsp_err, 2'b10);
        $display("[TB] timeout rid=0 wait_cycles=%0d err=%0d", cnt, rsp_err);
        wait_idle();

        // m_ready on the very cycle the timeout expires wins.
        set_req(1, 1'b0, 8'h20, 8'h00);
        wait_ack(g);
        check("race_grant", g, 1);
        req_valid[1] = 1'b0;
        cnt = 1;
        while (cnt < TIMEOUT_CYC) begin
            @(negedge clk);
            cnt++;
        end
        check("race_ce_last_cycle", m_ce, 1);
        m_ready = 1'b1;
        m_rdata = 8'h77;
        @(negedge clk);
        m_ready = 1'b0;
        check("race_ce_drop", m_ce, 0);
        check("race_rsp_valid", rsp_valid, 1 << 1);
        check("race_rsp_err", rsp_err, 2'b00);
        check("race_rsp_rdata", rsp_rdata, 8'h77);
        $display("[TB] timeout race rid=1 err=%0d rdata=0x%02h", rsp_err, rsp_rdata);
        wait_idle();

        // Stray master pulses outside WAIT are ignored.
        m_ready = 1'b1;
        m_error = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        m_error = 1'b0;
        @(negedge clk);
        check("stray_no_rsp", rsp_valid, 0);
        check("stray_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
